button_debounce: RTL and testbench
==================================

# button_debounce

Debounces one raw push-button input using the shared `timer` block as its settle-interval source. It sits directly upstream of `timer`: it drives the timer's START and consumes its PULSE. It emits a clean level plus one-cycle PRESS, RELEASE and LONG_PRESS events to the game/control logic. One `timer` instance is dedicated to each `button_debounce` instance.

## Interface
- `ACTIVE_LOW`, default 1: 1 means the raw button reads 0 when pressed.
- `SYNC_STAGES`, default 2: synchronizer depth; minimum 2.
- `LONG_TICKS`, default 8: number of consecutive timer intervals held after the press commits before LONG_PRESS fires. 0 disables long-press; range 0..255.

Ports:
- `CLK` in 1: single system clock; every flop is on its rising edge.
- `RST_N` in 1: reset, asynchronous and active-low.
- `BTN_RAW` in 1: asynchronous raw button pin.
- `TIMER_PULSE` in 1: one-cycle PULSE from `timer`.
- `TIMER_START` out 1: START to `timer`; one-cycle strobe.
- `BTN_LEVEL` out 1: debounced level; 1 means pressed, regardless of polarity.
- `PRESS` out 1: one-cycle strobe when a press commits.
- `RELEASE` out 1: one-cycle strobe when a release commits.
- `LONG_PRESS` out 1: one-cycle strobe, at most once per press.

## Operation
- **Input conditioning:** BTN_RAW passes through SYNC_STAGES flops, then is inverted when ACTIVE_LOW=1. The result is `btn_s`, where 1 means pressed.
- **Busy flag (`busy`):**
  - Set in the cycle TIMER_START is driven.
  - Cleared on TIMER_PULSE.
  - `timer` cannot be cancelled and ignores START while counting, so TIMER_START is never driven while `busy`=1.
- **States:**
  - STABLE:
    - If `btn_s` differs from BTN_LEVEL: go to DRAIN when `busy`=1, otherwise to ARM.
    - Else, if BTN_LEVEL=1, LONG_TICKS>0 and LONG_PRESS has not yet fired for this press: go to HOLD.
  - DRAIN: wait for TIMER_PULSE and discard it, then go to ARM.
  - ARM: drive TIMER_START=1 for exactly one cycle, then go to DEBOUNCE.
  - DEBOUNCE: on TIMER_PULSE, compare `btn_s` with BTN_LEVEL.
    - If they still differ, commit: toggle BTN_LEVEL, strobe PRESS (new level 1) or RELEASE (new level 0), clear `hold_cnt` and the long-fired flag, then go to STABLE.
    - If they are equal, the change was a bounce: no output, go to STABLE.
    - Changes on `btn_s` during DEBOUNCE are ignored; only the value in the PULSE cycle counts.
  - HOLD:
    - If `btn_s`=0: go to DRAIN when `busy`=1, otherwise to ARM. The release is then debounced normally.
    - Else, when `busy`=0, drive TIMER_START for one cycle.
    - On TIMER_PULSE, `hold_cnt` increments (8-bit, saturating). When the incremented value equals LONG_TICKS: strobe LONG_PRESS, set the long-fired flag, go to STABLE.
- PRESS, RELEASE and LONG_PRESS are mutually exclusive in any cycle.

## Timing
- **Reset (async assert):**
  - State becomes STABLE.
  - BTN_LEVEL, PRESS, RELEASE, LONG_PRESS and TIMER_START are 0.
  - `busy`, `hold_cnt` and the long-fired flag are 0.
  - Synchronizer flops reset to the "released" raw value (1 when ACTIVE_LOW=1).
  - Deassertion is consumed synchronously, with no glitch on outputs.
- **Reset mid-operation:** any pending interval is abandoned. `timer` shares RST_N, so it also returns to idle and no stale PULSE arrives.
- **Detect latency:** a raw edge reaches `btn_s` SYNC_STAGES cycles later. The transition out of STABLE happens on the next edge. TIMER_START is asserted one cycle after entering ARM's predecessor decision, i.e. the ARM cycle.
- **Commit latency:** PRESS/RELEASE and the BTN_LEVEL change are registered in the cycle after the TIMER_PULSE is sampled.
- **LONG_PRESS latency:** registered in the cycle after the LONG_TICKS-th hold PULSE.
- **Back-to-back intervals:** re-issuing START in the cycle after a PULSE is legal, because `timer` is idle while PULSE is high.
- **Simultaneous events:** TIMER_PULSE and a `btn_s` change in the same cycle in STABLE or HOLD:
  - The PULSE clears `busy` first.
  - The transition then goes to ARM, not DRAIN.

## Test plan
Bench timer model: PULSE 10 cycles after START. Parameters ACTIVE_LOW=1, LONG_TICKS=3.

1. **Clean press:** BTN_RAW 1→0 held.
   - TIMER_START appears 3 cycles after the edge.
   - PRESS appears one cycle after PULSE, and BTN_LEVEL becomes 1.
   - There is exactly one PRESS.
2. **Bounce rejected:** BTN_RAW goes 0 for 4 cycles, then back to 1.
   - One START and one PULSE occur.
   - No PRESS; BTN_LEVEL stays 0.
3. **Long press:** hold for 60 cycles.
   - PRESS, then three hold intervals, then one LONG_PRESS.
   - No further START until release.
4. **Release during HOLD with timer busy:**
   - Enter DRAIN and discard that PULSE.
   - A new START follows, then RELEASE after the second PULSE.
   - No LONG_PRESS occurs.
5. **Reset mid-DEBOUNCE:** assert RST_N=0 for 2 cycles, 5 cycles after START.
   - All outputs are 0 immediately, with no clock required.
   - No event is emitted after reset is released.
6. **ACTIVE_LOW=0 and LONG_TICKS=0:** BTN_RAW 0→1 held.
   - PRESS fires.
   - HOLD is never entered, and LONG_PRESS never fires.

Source files
------------

// File: rtl/button_debounce.sv
// Purpose : debounce one raw push-button against an external settle timer; emit a clean level plus PRESS/RELEASE/LONG_PRESS strobes.
// Latency : SYNC_STAGES cycles to btn_s, +1 to TIMER_START; commits are registered the cycle after the deciding TIMER_PULSE.
// Backpressure : none; TIMER_START is only issued while the timer is idle, and all events are single-cycle strobes.
module button_debounce #(
  parameter int unsigned ACTIVE_LOW  = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LONG_TICKS  = 8
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_RAW,
  input  logic TIMER_PULSE,
  output logic TIMER_START,
  output logic BTN_LEVEL,
  output logic PRESS,
  output logic RELEASE,
  output logic LONG_PRESS
);

  // Raw pin value that means "not pressed"; the synchronizer resets to it.
  localparam logic       RAW_RELEASED = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic       LONG_EN      = (LONG_TICKS != 0) ? 1'b1 : 1'b0;
  localparam logic [7:0] LONG_TICKS_B = 8'(LONG_TICKS);

  typedef enum logic [2:0] {
    ST_STABLE,
    ST_DRAIN,
    ST_ARM,
    ST_DEBOUNCE,
    ST_HOLD
  } state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    busy_q, busy_d;
  logic [7:0]              hold_cnt_q, hold_cnt_d;
  logic                    long_fired_q, long_fired_d;
  logic                    level_q, level_d;
  logic                    press_q, press_d;
  logic                    release_q, release_d;
  logic                    long_q, long_d;
  logic                    start_q, start_d;

  logic                    btn_s;
  logic                    busy_now;
  logic [7:0]              hold_inc;

  // Shift the raw pin through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], BTN_RAW};
  end

  // Normalise polarity so btn_s is 1 while pressed; a PULSE frees the timer
  // in the same cycle, so decisions made then see it as idle.
  assign btn_s    = sync_q[SYNC_STAGES-1] ^ RAW_RELEASED;
  assign busy_now = busy_q & ~TIMER_PULSE;

  // Next-state and registered-output decode for the debounce/hold sequencer.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    press_d      = 1'b0;
    release_d    = 1'b0;
    long_d       = 1'b0;
    start_d      = 1'b0;
    hold_cnt_d   = hold_cnt_q;
    long_fired_d = long_fired_q;
    hold_inc     = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;

    case (state_q)
      ST_STABLE: begin
        if (btn_s != level_q) begin
          if (busy_now) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ARM;
            start_d = 1'b1;
          end
        end else if (level_q && LONG_EN && !long_fired_q) begin
          state_d = ST_HOLD;
        end
      end

      // An interval we no longer care about is still running; let it expire.
      ST_DRAIN: begin
        if (TIMER_PULSE) begin
          state_d = ST_ARM;
          start_d = 1'b1;
        end
      end

      ST_ARM: begin
        state_d = ST_DEBOUNCE;
      end

      // Only the input value in the PULSE cycle decides the outcome.
      ST_DEBOUNCE: begin
        if (TIMER_PULSE) begin
          state_d = ST_STABLE;
          if (btn_s != level_q) begin
            level_d      = ~level_q;
            press_d      = ~level_q;
            release_d    = level_q;
            hold_cnt_d   = 8'd0;
            long_fired_d = 1'b0;
          end
        end
      end

      ST_HOLD: begin
        if (!btn_s) begin
          if (busy_now) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_ARM;
            start_d = 1'b1;
          end
        end else begin
          if (TIMER_PULSE) begin
            hold_cnt_d = hold_inc;
            if (hold_inc == LONG_TICKS_B) begin
              long_d       = 1'b1;
              long_fired_d = 1'b1;
              state_d      = ST_STABLE;
            end
          end
          // Back-to-back hold intervals: restart as soon as the timer is idle.
          if (!busy_now && (state_d == ST_HOLD)) begin
            start_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_STABLE;
      end
    endcase

    busy_d = start_d | busy_now;
  end

  // State and output registers; reset returns everything to released/idle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_STABLE;
      sync_q       <= {SYNC_STAGES{RAW_RELEASED}};
      busy_q       <= 1'b0;
      hold_cnt_q   <= 8'd0;
      long_fired_q <= 1'b0;
      level_q      <= 1'b0;
      press_q      <= 1'b0;
      release_q    <= 1'b0;
      long_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      busy_q       <= busy_d;
      hold_cnt_q   <= hold_cnt_d;
      long_fired_q <= long_fired_d;
      level_q      <= level_d;
      press_q      <= press_d;
      release_q    <= release_d;
      long_q       <= long_d;
      start_q      <= start_d;
    end
  end

  assign TIMER_START = start_q;
  assign BTN_LEVEL   = level_q;
  assign PRESS       = press_q;
  assign RELEASE     = release_q;
  assign LONG_PRESS  = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// Two debouncers (active-low/long=3 and active-high/long=0) driven by the same
// pressed/released pattern; each has its own 10-cycle timer model. Expected
// events are computed per episode from interval-level rules and scoreboarded.
module tb_button_debounce;

  localparam int MAXC = 400;

  typedef enum int {EV_START, EV_PRESS, EV_RELEASE, EV_LONG} ev_kind_e;
  typedef struct {
    int       inst;
    ev_kind_e kind;
    int       cyc;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [1:0] raw_i;
  logic [1:0] tpulse;
  logic [1:0] start_o, lvl_o, press_o, rel_o, long_o;
  logic [3:0] tcnt [2];

  int  edge_cnt = 0;
  int  ep_base  = 0;
  bit  mon_en   = 1'b0;
  int  checks   = 0;
  int  failures = 0;

  bit  prs [MAXC];          // pressed (1) / released (0) per cycle
  bit  exp_lvl [2][MAXC];
  ev_t exp_q [$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  button_debounce #(.ACTIVE_LOW(1), .SYNC_STAGES(2), .LONG_TICKS(3)) u_dut_lo (
    .CLK(CLK), .RST_N(RST_N), .BTN_RAW(raw_i[0]), .TIMER_PULSE(tpulse[0]),
    .TIMER_START(start_o[0]), .BTN_LEVEL(lvl_o[0]), .PRESS(press_o[0]),
    .RELEASE(rel_o[0]), .LONG_PRESS(long_o[0]));

  button_debounce #(.ACTIVE_LOW(0), .SYNC_STAGES(2), .LONG_TICKS(0)) u_dut_hi (
    .CLK(CLK), .RST_N(RST_N), .BTN_RAW(raw_i[1]), .TIMER_PULSE(tpulse[1]),
    .TIMER_START(start_o[1]), .BTN_LEVEL(lvl_o[1]), .PRESS(press_o[1]),
    .RELEASE(rel_o[1]), .LONG_PRESS(long_o[1]));

  // Timer model: PULSE in the 10th cycle after the START cycle; START ignored while counting.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) tcnt[i] <= 4'd0;
      tpulse <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        tpulse[i] <= 1'b0;
        if (tcnt[i] != 4'd0) begin
          tcnt[i] <= tcnt[i] - 4'd1;
          if (tcnt[i] == 4'd1) tpulse[i] <= 1'b1;
        end else if (start_o[i]) begin
          tcnt[i] <= 4'd9;
        end
      end
    end
  end

  // Synchronized, polarity-normalised button as seen by the debouncer.
  function automatic bit bsv(input int c);
    return (c >= 2) ? prs[c-2] : 1'b0;
  endfunction

  function automatic void push_ev(input int inst, input ev_kind_e k, input int c, input int n);
    ev_t e;
    e.inst = inst; e.kind = k; e.cyc = c;
    if (c < n) exp_q.push_back(e);
  endfunction

  // Interval-level reference: each timer interval is START at s, PULSE at s+10;
  // a debounce commits iff the button still differs at the PULSE.
  function automatic void run_model(input int inst, input int lt, input int n);
    bit lvl = 1'b0;
    bit fired = 1'b0;
    int hc = 0;
    int t = 0;
    int lv_from = 0;
    int s, p, h, nxt;
    while (t < n) begin
      s = -1;
      nxt = t + 1;
      if (bsv(t) != lvl) begin
        s = t + 1;
      end else if (lvl && lt > 0 && !fired) begin
        h = t + 1;
        if (!bsv(h)) begin
          s = h + 1;
        end else begin
          nxt = -1;
          while (s < 0 && nxt < 0) begin
            if (h >= n) begin
              nxt = n;
            end else begin
              push_ev(inst, EV_START, h + 1, n);
              p = h + 11;
              for (int c = h + 1; c <= p; c++)
                if (s < 0 && !bsv(c)) s = p + 1;
              if (s < 0) begin
                hc = (hc >= 255) ? 255 : hc + 1;
                if (hc == lt) begin
                  push_ev(inst, EV_LONG, p + 1, n);
                  fired = 1'b1;
                  nxt = p + 1;
                end else begin
                  h = p;
                end
              end
            end
          end
        end
      end
      if (s >= 0) begin
        push_ev(inst, EV_START, s, n);
        p = s + 10;
        if (bsv(p) != lvl) begin
          for (int c = lv_from; c <= p && c < n; c++) exp_lvl[inst][c] = lvl;
          lv_from = p + 1;
          lvl = ~lvl;
          push_ev(inst, lvl ? EV_PRESS : EV_RELEASE, p + 1, n);
          hc = 0;
          fired = 1'b0;
        end
        nxt = p + 1;
      end
      t = nxt;
    end
    for (int c = lv_from; c < n; c++) exp_lvl[inst][c] = lvl;
  endfunction

  task automatic match_ev(input int i, input ev_kind_e k, input int c);
    int idx = -1;
    foreach (exp_q[j]) if (idx < 0 && exp_q[j].inst == i && exp_q[j].kind == k) idx = j;
    checks++;
    if (idx < 0) begin
      failures++;
      $display("FAIL unexpected_%s inst=%0d got strobe at cycle %0d required none", k.name(), i, c);
    end else begin
      if (exp_q[idx].cyc != c) begin
        failures++;
        $display("FAIL %s_cycle inst=%0d got %0d required %0d", k.name(), i, c, exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  task automatic monitor_loop();
    int c;
    int nev;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        c = edge_cnt - ep_base;
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (lvl_o[i] !== exp_lvl[i][c]) begin
            failures++;
            $display("FAIL btn_level inst=%0d cycle=%0d got %b required %b", i, c, lvl_o[i], exp_lvl[i][c]);
          end
          nev = int'(press_o[i]) + int'(rel_o[i]) + int'(long_o[i]);
          checks++;
          if (nev > 1) begin
            failures++;
            $display("FAIL exclusive inst=%0d cycle=%0d got %0d strobes required at most 1", i, c, nev);
          end
          if (start_o[i] === 1'b1) begin
            checks++;
            if (tcnt[i] != 4'd0) begin
              failures++;
              $display("FAIL start_while_busy inst=%0d cycle=%0d got remaining=%0d required 0", i, c, tcnt[i]);
            end
            match_ev(i, EV_START, c);
          end
          if (press_o[i] === 1'b1) match_ev(i, EV_PRESS, c);
          if (rel_o[i] === 1'b1) match_ev(i, EV_RELEASE, c);
          if (long_o[i] === 1'b1) match_ev(i, EV_LONG, c);
        end
      end
    end
  endtask

  function automatic logic [1:0] drive(input bit p);
    return {p, ~p};
  endfunction

  task automatic clear_prs();
    for (int c = 0; c < MAXC; c++) prs[c] = 1'b0;
  endtask

  task automatic set_prs(input int from, input int to, input bit v);
    for (int c = from; c < to && c < MAXC; c++) prs[c] = v;
  endtask

  // Async reset mid-cycle (checked with no clock edge), then run n cycles of prs.
  task automatic run_episode(input int n);
    exp_q.delete();
    run_model(0, 3, n);
    run_model(1, 0, n);
    @(posedge CLK);
    #2;
    mon_en = 1'b0;
    RST_N  = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({start_o[i], lvl_o[i], press_o[i], rel_o[i], long_o[i]} !== 5'b0) begin
        failures++;
        $display("FAIL reset_outputs inst=%0d got %b required 00000", i,
                 {start_o[i], lvl_o[i], press_o[i], rel_o[i], long_o[i]});
      end
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N   = 1'b1;
    raw_i   = drive(prs[0]);
    ep_base = edge_cnt;
    mon_en  = 1'b1;
    for (int c = 1; c < n; c++) begin
      @(negedge CLK);
      raw_i = drive(prs[c]);
    end
    @(posedge CLK);
    #2;
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      foreach (exp_q[j])
        $display("FAIL missing_%s inst=%0d got none required cycle %0d",
                 exp_q[j].kind.name(), exp_q[j].inst, exp_q[j].cyc);
    end
  endtask

  initial begin
    int n;
    int c;
    int len;
    bit v;
    RST_N = 1'b1;
    raw_i = 2'b01;
    fork
      monitor_loop();
    join_none

    clear_prs(); set_prs(5, MAXC, 1'b1); run_episode(45);   // clean press
    clear_prs(); set_prs(5, 9, 1'b1);    run_episode(40);   // 4-cycle bounce
    clear_prs(); set_prs(5, 65, 1'b1);   run_episode(110);  // long press then release
    clear_prs(); set_prs(5, 30, 1'b1);   run_episode(70);   // release while hold interval busy
    clear_prs(); set_prs(5, MAXC, 1'b1); run_episode(12);   // reset lands mid-debounce
    clear_prs();                         run_episode(30);   // nothing stale after reset

    for (int e = 0; e < 10; e++) begin
      clear_prs();
      n = $urandom_range(120, 300);
      c = 4;
      v = 1'b0;
      while (c < n + 32) begin
        len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 14) : $urandom_range(15, 70);
        v = ~v;
        set_prs(c, c + len, v);
        c += len;
      end
      run_episode(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
